// File: rtl/fwd_ctrl.sv
// Forwarding select and load-use stall control for the EX-stage operand muxes.
// Latency: fwd_a_o/fwd_b_o registered, valid for the cycle the instruction is in EX; stall_o combinational.
// Backpressure: stall_o holds PC/IF/ID and inserts an EX bubble for one cycle per load-use pair.
module fwd_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] SEL_IDEX  = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    // In-flight destination tracking. A producer in WB needs no tracking: the
    // register file is write-through, so ID already reads its result.
    logic             ex_vld;
    logic [REG_W-1:0] ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             mem_vld;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;

    logic             bubble;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;

    // Youngest writing producer wins; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] pick_sel(
        input logic             use_src,
        input logic [REG_W-1:0] src,
        input logic             ex_wr,
        input logic [REG_W-1:0] ex_dst,
        input logic             mem_wr,
        input logic [REG_W-1:0] mem_dst
    );
        logic [1:0] sel;
        sel = SEL_IDEX;
        if (use_src && src != '0) begin
            if (ex_wr && ex_dst == src) begin
                sel = SEL_EXMEM;
            end else if (mem_wr && mem_dst == src) begin
                sel = SEL_MEMWB;
            end
        end
        return sel;
    endfunction

    // Load in EX feeding an ID source cannot be forwarded in time: stall one cycle.
    always_comb begin
        stall_o = id_valid_i && !flush_i && ex_vld && ex_memread && (ex_rd != '0) &&
                  ((id_use_rs_i && ex_rd == id_rs_i) || (id_use_rt_i && ex_rd == id_rt_i));
        bubble  = stall_o || flush_i || !id_valid_i;
        sel_a   = pick_sel(id_use_rs_i, id_rs_i, ex_vld && ex_regwrite, ex_rd,
                           mem_vld && mem_regwrite, mem_rd);
        sel_b   = pick_sel(id_use_rt_i, id_rt_i, ex_vld && ex_regwrite, ex_rd,
                           mem_vld && mem_regwrite, mem_rd);
    end

    // Advance the tracker and register the selects alongside the ID->EX move.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_vld       <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_vld      <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            fwd_a_o      <= SEL_IDEX;
            fwd_b_o      <= SEL_IDEX;
        end else begin
            mem_vld      <= ex_vld;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            ex_vld       <= !bubble;
            ex_rd        <= id_rd_i;
            ex_regwrite  <= id_regwrite_i;
            ex_memread   <= id_memread_i;
            fwd_a_o      <= bubble ? SEL_IDEX : sel_a;
            fwd_b_o      <= bubble ? SEL_IDEX : sel_b;
        end
    end

    // Saturating count of stall cycles; sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed scenarios then randomized traffic
// checked against an issue-history reference model.
module tb_fwd_ctrl;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic             clk_i;
    logic             rst_i;
    logic             id_valid_i;
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_use_rs_i;
    logic             id_use_rt_i;
    logic [REG_W-1:0] id_rd_i;
    logic             id_regwrite_i;
    logic             id_memread_i;
    logic             flush_i;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic             stall_o;
    logic [CNT_W-1:0] stall_cnt_o;

    fwd_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             urs;
        logic             urt;
        logic [REG_W-1:0] rd;
        logic             rw;
        logic             mr;
        logic             fl;
    } id_t;

    // What entered EX each cycle (bubbles included), newest at index 0.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             rw;
        logic             mr;
    } issued_t;

    issued_t hist[$];
    int      m_cnt;
    int      checks;
    int      errors;

    function automatic id_t mk(logic v, int rs, int rt, logic urs, logic urt,
                               int rd, logic rw, logic mr, logic fl);
        id_t i;
        i.v = v; i.rs = REG_W'(rs); i.rt = REG_W'(rt); i.urs = urs; i.urt = urt;
        i.rd = REG_W'(rd); i.rw = rw; i.mr = mr; i.fl = fl;
        return i;
    endfunction

    // Most recent writer of src among the last two issued instructions.
    function automatic logic [1:0] model_sel(logic [REG_W-1:0] src, logic used);
        if (!used || src == 0) return 2'b00;
        for (int age = 0; age < 2 && age < hist.size(); age++) begin
            if (hist[age].valid && hist[age].rw && hist[age].rd == src)
                return (age == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic model_stall(id_t i);
        if (!i.v || i.fl || hist.size() == 0) return 1'b0;
        if (!hist[0].valid || !hist[0].mr || hist[0].rd == 0) return 1'b0;
        return (i.urs && i.rs == hist[0].rd) || (i.urt && i.rt == hist[0].rd);
    endfunction

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: drive ID, check stall mid-cycle, check registered outputs after the edge.
    task automatic step(input id_t i, output logic st);
        logic       m_st;
        logic       bub;
        logic [1:0] ea;
        logic [1:0] eb;
        issued_t    e;
        id_valid_i = i.v; id_rs_i = i.rs; id_rt_i = i.rt;
        id_use_rs_i = i.urs; id_use_rt_i = i.urt; id_rd_i = i.rd;
        id_regwrite_i = i.rw; id_memread_i = i.mr; flush_i = i.fl;
        #3;
        m_st = model_stall(i);
        chk("stall_o", 16'(stall_o), 16'(m_st));
        bub = m_st || i.fl || !i.v;
        ea  = bub ? 2'b00 : model_sel(i.rs, i.urs);
        eb  = bub ? 2'b00 : model_sel(i.rt, i.urt);
        if (m_st && m_cnt < CNT_MAX) m_cnt++;
        e.valid = !bub; e.rd = i.rd; e.rw = i.rw; e.mr = i.mr;
        @(posedge clk_i);
        #1;
        hist.push_front(e);
        if (hist.size() > 3) void'(hist.pop_back());
        chk("fwd_a_o", 16'(fwd_a_o), 16'(ea));
        chk("fwd_b_o", 16'(fwd_b_o), 16'(eb));
        chk("stall_cnt_o", 16'(stall_cnt_o), 16'(m_cnt));
        st = m_st;
    endtask

    task automatic rand_inputs();
        id_valid_i = 1'($urandom); id_rs_i = REG_W'($urandom); id_rt_i = REG_W'($urandom);
        id_use_rs_i = 1'($urandom); id_use_rt_i = 1'($urandom); id_rd_i = REG_W'($urandom);
        id_regwrite_i = 1'($urandom); id_memread_i = 1'($urandom); flush_i = 1'($urandom);
    endtask

    // Hold reset for a few cycles under random inputs, release at posedge+1.
    task automatic do_reset();
        rst_i = 1'b0;
        hist.delete();
        m_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            #3;
            chk("rst fwd_a_o", 16'(fwd_a_o), 16'h0);
            chk("rst fwd_b_o", 16'(fwd_b_o), 16'h0);
            chk("rst stall_o", 16'(stall_o), 16'h0);
            chk("rst stall_cnt_o", 16'(stall_cnt_o), 16'h0);
            @(posedge clk_i);
            #1;
        end
        rst_i = 1'b1;
    endtask

    logic       st;
    id_t        cur;
    logic [1:0] sat_exp [5];

    initial begin
        checks = 0; errors = 0; m_cnt = 0;
        rst_i = 1'b0;
        id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_use_rs_i = 1'b0; id_use_rt_i = 1'b0;
        id_rd_i = '0; id_regwrite_i = 1'b0; id_memread_i = 1'b0; flush_i = 1'b0;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(posedge clk_i);
        #1;
        do_reset();

        // Nothing in flight: no forwarding
        step(mk(1, 3, 0, 1, 0, 8, 1, 0, 0), st);
        chk("idle rs3 fwd_a", 16'(fwd_a_o), 16'h0);

        // Load-use: stall, EX bubble, then MEM/WB forward
        step(mk(1, 1, 0, 1, 0, 4, 1, 1, 0), st);
        step(mk(1, 4, 2, 1, 1, 9, 1, 0, 0), st);
        chk("lu stall", 16'(st), 16'h1);
        chk("lu bubble sel", 16'(fwd_a_o), 16'h0);
        chk("lu cnt", 16'(stall_cnt_o), 16'h1);
        step(mk(1, 4, 2, 1, 1, 9, 1, 0, 0), st);
        chk("lu re-present stall", 16'(st), 16'h0);
        chk("lu re-present fwd_a", 16'(fwd_a_o), 16'h1);

        // EX-distance forward on both operands
        step(mk(1, 1, 2, 1, 1, 5, 1, 0, 0), st);
        step(mk(1, 5, 5, 1, 1, 6, 1, 0, 0), st);
        chk("ex fwd_a", 16'(fwd_a_o), 16'h2);
        chk("ex fwd_b", 16'(fwd_b_o), 16'h2);

        // Younger producer wins, then MEM-distance alone
        step(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), st);
        step(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), st);
        step(mk(1, 7, 0, 1, 0, 8, 1, 0, 0), st);
        chk("prio fwd_a", 16'(fwd_a_o), 16'h2);
        step(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), st);
        step(mk(1, 1, 0, 1, 0, 12, 1, 0, 0), st);
        step(mk(1, 7, 0, 1, 0, 8, 1, 0, 0), st);
        chk("mem fwd_a", 16'(fwd_a_o), 16'h1);

        // Register 0 never forwarded nor stalls
        step(mk(1, 0, 0, 0, 0, 0, 1, 1, 0), st);
        step(mk(1, 0, 0, 1, 1, 3, 1, 0, 0), st);
        chk("r0 stall", 16'(st), 16'h0);
        chk("r0 fwd_a", 16'(fwd_a_o), 16'h0);

        // Flush beats stall and inserts a bubble
        step(mk(1, 1, 0, 1, 0, 4, 1, 1, 0), st);
        step(mk(1, 4, 0, 1, 0, 9, 1, 0, 1), st);
        chk("flush stall", 16'(st), 16'h0);
        chk("flush bubble fwd_a", 16'(fwd_a_o), 16'h0);

        // Mid-operation async reset clears tracking at once
        step(mk(1, 0, 0, 0, 0, 3, 1, 0, 0), st);
        rand_inputs();
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst fwd_a_o", 16'(fwd_a_o), 16'h0);
        chk("arst fwd_b_o", 16'(fwd_b_o), 16'h0);
        chk("arst stall_cnt_o", 16'(stall_cnt_o), 16'h0);
        chk("arst stall_o", 16'(stall_o), 16'h0);
        hist.delete();
        m_cnt = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        step(mk(1, 3, 0, 1, 0, 8, 1, 0, 0), st);
        chk("post-rst fwd_a", 16'(fwd_a_o), 16'h0);

        // Counter saturation
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(mk(1, 1, 0, 1, 0, 4, 1, 1, 0), st);
            step(mk(1, 4, 0, 1, 0, 9, 1, 0, 0), st);
            chk("sat cnt", 16'(stall_cnt_o), 16'(sat_exp[k]));
            step(mk(1, 4, 0, 1, 0, 9, 1, 0, 0), st);
        end

        // Randomized traffic; a stalled instruction is re-presented
        do_reset();
        st = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!st) begin
                cur = mk($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                         1'($urandom), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                         $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            end
            step(cur, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
